// File: rtl/sipo_load_ctrl.sv
// Serializes a parallel word LSB-first into an external SIPO register, then captures
// the SIPO's parallel output and returns it with a mismatch flag over valid/ready.
module sipo_load_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             stall,
  output logic             serial_a,
  output logic             shift_a,
  input  logic [WIDTH-1:0] sipo_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             mismatch,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CAPT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_buf;
  logic [WIDTH-1:0] orig;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_buf <= '0;
      orig      <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_buf <= in_data;
            orig      <= in_data;
            cnt       <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (!stall) begin
            shift_buf <= shift_buf >> 1;
            // Last bit leaves the counter at zero so it never reaches WIDTH.
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= CAPT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        CAPT: begin
          out_data  <= sipo_data;
          mismatch  <= (sipo_data != orig);
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // shift_a also gated by rst so the SIPO cannot move in the cycle reset is first seen.
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign serial_a = (state == SHIFT) & shift_buf[0];
  assign shift_a  = (state == SHIFT) & ~stall & ~rst;

endmodule

// File: tb/tb_sipo_load_ctrl.sv
// Directed bench for sipo_load_ctrl with a behavioural 4-bit SIPO as the load;
// expected bit streams, latencies and results are hand-derived per test.
module tb_sipo_load_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       stall;
  logic       serial_a;
  logic       shift_a;
  logic [3:0] sipo_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       mismatch;
  logic       busy;

  logic [3:0] sipo_q = 4'h0;
  logic       force_en;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // SIPO load: right shift with the new bit entering at the MSB.
  always @(posedge clk) if (shift_a) sipo_q <= {serial_a, sipo_q[3:1]};
  assign sipo_data = force_en ? 4'h0 : sipo_q;

  sipo_load_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .stall(stall), .serial_a(serial_a), .shift_a(shift_a),
    .sipo_data(sipo_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .mismatch(mismatch), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at cycle 0 (just after an edge). Returns at the first HOLD cycle.
  task automatic run_word(input logic [3:0] d, input logic [15:0] stall_mask,
                          input bit force0, input bit hold_valid, input int exp_ov_cycle);
    int c;
    int k;
    logic [3:0] dr;
    dr = d;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    chk("accept_ready", in_ready, 1);
    chk("idle_shift", shift_a, 0);
    tick();
    if (!hold_valid) in_valid = 1'b0;
    c = 1;
    k = 0;
    while (k < 4 && c < 20) begin
      stall = stall_mask[c];
      #1;
      chk("shift_a", shift_a, !stall);
      chk("serial_a", serial_a, dr[k]);
      chk("ready_busy", in_ready, 0);
      chk("busy", busy, 1);
      if (!stall) k++;
      tick();
      c++;
    end
    stall = 1'b0;
    chk("shift_count", k, 4);
    #1;
    chk("capt_shift", shift_a, 0);
    chk("capt_serial", serial_a, 0);
    chk("capt_valid", out_valid, 0);
    if (force0) begin
      force_en = 1'b1;
      #1;
    end
    tick();
    c++;
    force_en = 1'b0;
    chk("ov_cycle", c, exp_ov_cycle);
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, force0 ? 4'h0 : d);
    chk("mismatch", mismatch, force0);
    chk("hold_ready", in_ready, 0);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    chk("rel_ready", in_ready, 1);
    chk("rel_valid", out_valid, 0);
    chk("rel_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; stall = 1'b0;
    out_ready = 1'b0; force_en = 1'b0;
    #1;
    chk("rst_shift_first", shift_a, 0);
    tick();
    tick();
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_mis", mismatch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_shift", shift_a, 0);
    rst = 1'b0;

    // 1: 1011 with out_ready high throughout, result in cycle 6
    out_ready = 1'b1;
    run_word(4'b1011, 16'h0000, 1'b0, 1'b0, 6);
    tick();
    chk("t1_idle_ready", in_ready, 1);
    chk("t1_idle_valid", out_valid, 0);
    out_ready = 1'b0;

    // 2: 0xA with stall in cycles 2-3, result in cycle 8
    run_word(4'hA, 16'h000C, 1'b0, 1'b0, 8);
    release_out();
    out_ready = 1'b0;

    // 3: 0x5 held for 5 cycles without out_ready
    run_word(4'h5, 16'h0000, 1'b0, 1'b0, 6);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_data", out_data, 4'h5);
      chk("t3_hold_mis", mismatch, 0);
      chk("t3_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("t3_same_cycle_ready", in_ready, 0);
    release_out();
    out_ready = 1'b0;

    // 4: shift 0xF, SIPO forced to 0 at capture
    run_word(4'hF, 16'h0000, 1'b1, 1'b0, 6);
    release_out();
    out_ready = 1'b0;

    // 5: reset in cycle 2 of a transfer, then 0x3
    in_valid = 1'b1;
    in_data  = 4'h6;
    tick();
    in_valid = 1'b0;
    #1;
    chk("t5_c1_shift", shift_a, 1);
    tick();
    rst = 1'b1;
    #1;
    chk("t5_rst_shift", shift_a, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_ready", in_ready, 1);
    chk("t5_valid", out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_shift", shift_a, 0);
    run_word(4'h3, 16'h0000, 1'b0, 1'b0, 6);
    release_out();
    out_ready = 1'b0;

    // 6: in_valid held across back-to-back words 0x1 then 0xE
    run_word(4'h1, 16'h0000, 1'b0, 1'b1, 6);
    release_out();
    out_ready = 1'b0;
    run_word(4'hE, 16'h0000, 1'b0, 1'b1, 6);
    in_valid = 1'b0;
    release_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
